// File: rtl/alu2_result_stage.sv
// Registered FIFO output stage behind the alu4_cl ALU, with a saturating count of popped k=1 results.
// Optional parity storage is built when ALU2_RES_PARITY_EN is defined; otherwise out_par is tied to 0.
module alu2_result_stage #(
   parameter int DEPTH = 4,
   parameter int CW    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [5:0]               in_res,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [5:0]               out_res,
   output logic                     out_par,
   output logic [$clog2(DEPTH):0]   level,
   input  logic                     clr_count,
   output logic [CW-1:0]            count_k
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [5:0]    res_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level_nxt;
   logic          push;
   logic          pop;

   // Handshake flags come from registered occupancy only, so out_ready never reaches in_ready.
   assign in_ready  = (level != FULL_LVL);
   assign out_valid = (level != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_res   = res_mem[rd_ptr];

   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      level_nxt = level;
      case ({push, pop})
         2'b10:   level_nxt = level + LW'(1);
         2'b01:   level_nxt = level - LW'(1);
         default: level_nxt = level;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         level <= level_nxt;
      end
   end

   // NOTE: storage is reset too, because out_res must read 0 after reset rather than stale contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) res_mem[i] <= '0;
      end else if (push) begin
         res_mem[wr_ptr] <= in_res;
      end
   end

`ifdef ALU2_RES_PARITY_EN
   logic par_mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) par_mem[i] <= 1'b0;
      end else if (push) begin
         par_mem[wr_ptr] <= ^in_res;
      end
   end

   assign out_par = par_mem[rd_ptr];
`else
   assign out_par = 1'b0;
`endif

   // Clear wins over an increment landing on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_k <= '0;
      end else if (clr_count) begin
         count_k <= '0;
      end else if (pop && out_res[5] && (count_k != '1)) begin
         count_k <= count_k + CW'(1);
      end
   end

endmodule

// File: tb/tb_alu2_result_stage.sv
// Self-checking bench for alu2_result_stage (DEPTH=4, CW=2): vector table, hand sequences, randomized model check.
module tb_alu2_result_stage;

   localparam int DEPTH = 4;
   localparam int CW    = 2;
   localparam int LW    = 3;
   localparam int KMAX  = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [5:0]    in_res = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [5:0]    out_res;
   logic          out_par;
   logic [LW-1:0] level;
   logic          clr_count = 1'b0;
   logic [CW-1:0] count_k;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu2_result_stage #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_res    (in_res),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_par   (out_par),
      .level     (level),
      .clr_count (clr_count),
      .count_k   (count_k)
   );

   typedef struct {
      logic       iv;
      logic [5:0] ir;
      logic       ordy;
      logic       clr;
      int         lvl;
      logic       ov;
      logic       irdy;
      logic [5:0] ores;
      int         cnt;
   } vec_t;

   vec_t vecs[15];

   function automatic logic exp_par(input logic [5:0] r);
`ifdef ALU2_RES_PARITY_EN
      return ^r;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [5:0] ir, input logic ordy, input logic clr);
      in_valid  = iv;
      in_res    = ir;
      out_ready = ordy;
      clr_count = clr;
   endtask

   task automatic do_reset();
      drive(1'b0, 6'h0, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [5:0] q[$];
   int         mcnt;
   logic [5:0] head;
   logic       mpush;
   logic       mpop;
   logic       iv_r;
   logic       or_r;
   logic       clr_r;
   logic [5:0] ir_r;

   initial begin
      // Hand-derived vectors: inputs for one cycle, then outputs expected right after that edge.
      vecs[0]  = '{1'b1, 6'b100001, 1'b0, 1'b0, 1, 1'b1, 1'b1, 6'b100001, 0};
      vecs[1]  = '{1'b1, 6'b010000, 1'b0, 1'b0, 2, 1'b1, 1'b1, 6'b100001, 0};
      vecs[2]  = '{1'b1, 6'b111111, 1'b0, 1'b0, 3, 1'b1, 1'b1, 6'b100001, 0};
      vecs[3]  = '{1'b0, 6'b000000, 1'b1, 1'b0, 2, 1'b1, 1'b1, 6'b010000, 1};
      vecs[4]  = '{1'b0, 6'b000000, 1'b1, 1'b0, 1, 1'b1, 1'b1, 6'b111111, 1};
      vecs[5]  = '{1'b0, 6'b000000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 6'b000000, 2};
      vecs[6]  = '{1'b1, 6'b000010, 1'b0, 1'b0, 1, 1'b1, 1'b1, 6'b000010, 2};
      vecs[7]  = '{1'b1, 6'b000100, 1'b0, 1'b0, 2, 1'b1, 1'b1, 6'b000010, 2};
      vecs[8]  = '{1'b1, 6'b001000, 1'b0, 1'b0, 3, 1'b1, 1'b1, 6'b000010, 2};
      vecs[9]  = '{1'b1, 6'b010001, 1'b0, 1'b0, 4, 1'b1, 1'b0, 6'b000010, 2};
      vecs[10] = '{1'b1, 6'b000001, 1'b0, 1'b0, 4, 1'b1, 1'b0, 6'b000010, 2};
      vecs[11] = '{1'b1, 6'b000001, 1'b1, 1'b0, 3, 1'b1, 1'b1, 6'b000100, 2};
      vecs[12] = '{1'b0, 6'b000000, 1'b1, 1'b0, 2, 1'b1, 1'b1, 6'b001000, 2};
      vecs[13] = '{1'b0, 6'b000000, 1'b1, 1'b0, 1, 1'b1, 1'b1, 6'b010001, 2};
      vecs[14] = '{1'b0, 6'b000000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 6'b000000, 2};

      do_reset();
      check("rst_level", int'(level), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_res", int'(out_res), 0);
      check("rst_out_par", int'(out_par), 0);
      check("rst_count_k", int'(count_k), 0);

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].iv, vecs[i].ir, vecs[i].ordy, vecs[i].clr);
         step();
         check($sformatf("vec%0d_level", i), int'(level), vecs[i].lvl);
         check($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vecs[i].ov));
         check($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vecs[i].irdy));
         check($sformatf("vec%0d_count_k", i), int'(count_k), vecs[i].cnt);
         if (vecs[i].ov) begin
            check($sformatf("vec%0d_out_res", i), int'(out_res), int'(vecs[i].ores));
            check($sformatf("vec%0d_out_par", i), int'(out_par), int'(exp_par(vecs[i].ores)));
         end
      end

      // Streaming at level 2 across pointer wrap.
      do_reset();
      drive(1'b1, 6'd0, 1'b0, 1'b0); step();
      drive(1'b1, 6'd1, 1'b0, 1'b0); step();
      check("stream_prime_level", int'(level), 2);
      for (int i = 2; i < 12; i++) begin
         drive(1'b1, 6'(i), 1'b1, 1'b0);
         step();
         check($sformatf("stream%0d_level", i), int'(level), 2);
         check($sformatf("stream%0d_out_res", i), int'(out_res), i - 1);
      end

      // Saturation of count_k at 2^CW-1, then clear beating a same-cycle increment.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 6'b100000 | 6'(i), 1'b0, 1'b0); step();
         drive(1'b0, 6'h0, 1'b1, 1'b0); step();
         check($sformatf("sat%0d_count_k", i), int'(count_k), (i + 1 > KMAX) ? KMAX : i + 1);
      end
      drive(1'b1, 6'b100000, 1'b0, 1'b0); step();
      drive(1'b0, 6'h0, 1'b1, 1'b1); step();
      check("clr_vs_inc_count_k", int'(count_k), 0);
      check("clr_vs_inc_level", int'(level), 0);

      // Parity of stored entries.
      do_reset();
      drive(1'b1, 6'b000111, 1'b0, 1'b0); step();
      drive(1'b1, 6'b000011, 1'b0, 1'b0); step();
      check("par_head0", int'(out_par), int'(exp_par(6'b000111)));
      drive(1'b0, 6'h0, 1'b1, 1'b0); step();
      check("par_head1_res", int'(out_res), 6'b000011);
      check("par_head1", int'(out_par), int'(exp_par(6'b000011)));

      // Asynchronous reset in the middle of a stream.
      do_reset();
      drive(1'b1, 6'b100001, 1'b0, 1'b0); step();
      drive(1'b1, 6'b100010, 1'b1, 1'b0); step();
      drive(1'b1, 6'b000011, 1'b0, 1'b0); step();
      drive(1'b1, 6'b000100, 1'b0, 1'b0); step();
      check("mid_pre_level", int'(level), 3);
      check("mid_pre_count_k", int'(count_k), 1);
      drive(1'b0, 6'h0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", int'(out_valid), 0);
      check("mid_rst_level", int'(level), 0);
      check("mid_rst_count_k", int'(count_k), 0);
      check("mid_rst_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b1, 6'b010101, 1'b0, 1'b0); step();
      drive(1'b0, 6'h0, 1'b0, 1'b0);
      check("post_rst_out_valid", int'(out_valid), 1);
      check("post_rst_out_res", int'(out_res), 6'b010101);
      check("post_rst_level", int'(level), 1);

      // Randomized traffic against a queue model.
      do_reset();
      q.delete();
      mcnt = 0;
      for (int c = 0; c < 600; c++) begin
         if (((c / 64) % 2) == 0) begin
            iv_r = ($urandom % 4) != 0;
            or_r = ($urandom % 4) == 0;
         end else begin
            iv_r = ($urandom % 4) == 0;
            or_r = ($urandom % 4) != 0;
         end
         clr_r = ($urandom % 23) == 0;
         ir_r  = 6'($urandom);
         drive(iv_r, ir_r, or_r, clr_r);
         mpush = iv_r && (q.size() < DEPTH);
         mpop  = or_r && (q.size() > 0);
         head  = (q.size() > 0) ? q[0] : 6'h0;
         step();
         if (mpop) begin
            void'(q.pop_front());
            if (head[5] && mcnt < KMAX) mcnt++;
         end
         if (clr_r) mcnt = 0;
         if (mpush) q.push_back(ir_r);
         check("rnd_level", int'(level), q.size());
         check("rnd_out_valid", int'(out_valid), int'(q.size() != 0));
         check("rnd_in_ready", int'(in_ready), int'(q.size() != DEPTH));
         check("rnd_count_k", int'(count_k), mcnt);
         if (q.size() != 0) begin
            check("rnd_out_res", int'(out_res), int'(q[0]));
            check("rnd_out_par", int'(out_par), int'(exp_par(q[0])));
         end
      end
      drive(1'b0, 6'h0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
